// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction fetch queue.
//   - FETCH_PC_W    : default program-counter width
//   - NOP_INS       : instruction word shown to the decoder when there is no
//                     usable instruction (empty queue or fetch address error)
//   - fetch_entry_t : one buffered fetch result {pc, ins, adel}
package fetch_pkg;

  localparam int FETCH_PC_W = 32;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           ins;
    logic                  adel;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Decoupling FIFO between the I-cache side of fetch and the ID-stage decoder.
//   Entries are {pc, instruction, fetch-address-error}. The head entry is
//   presented first-word-fall-through from registered storage; an empty
//   queue presents a NOP. Flush (redirect/exception/eret) discards everything.
//
// Ports
//   clk        in   single clock, all state on posedge
//   rst        in   synchronous active-high reset
//   flush      in   discard all entries; wins over push/pop
//   in_valid   in   fetch side presents an entry
//   in_ready   out  entry accepted this cycle (= not full)
//   in_pc      in   pc of fetched instruction
//   in_ins     in   fetched instruction word
//   in_adel    in   fetch address error flag
//   out_valid  out  head entry valid (= not empty)
//   out_ready  in   decoder consumes head this cycle
//   out_pc     out  head pc, 0 when empty
//   out_ins    out  head instruction, NOP when empty or head has adel
//   out_adel   out  head carries fetch address error, 0 when empty
//   count      out  occupancy
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = FETCH_PC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_ins,
  input  logic                       in_adel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_ins,
  output logic                       out_adel,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  fetch_entry_t     mem_reg [DEPTH];

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         clear;
  fetch_entry_t in_entry;
  fetch_entry_t head;

  // Occupancy alone decides full/empty; pointers may be equal in both cases.
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  // in_ready depends only on the registered count, so a pop in the same
  // cycle never opens room for a push into a full queue.
  assign push  = in_valid && !full;
  assign pop   = out_ready && !empty;
  assign clear = rst || flush;

  assign in_entry.pc   = in_pc;
  assign in_entry.ins  = in_ins;
  assign in_entry.adel = in_adel;

  // Pointers and occupancy; power-of-two DEPTH gives natural wrap.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Storage is not reset; stale contents are masked by the empty check.
  // A write never targets the head slot while the head is visible, so the
  // outputs stay stable during a decoder stall.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_reg[wr_ptr_reg] <= in_entry;
    end
  end

  assign head = mem_reg[rd_ptr_reg];

  always_comb begin
    in_ready  = !full;
    out_valid = !empty;
    out_pc    = '0;
    out_ins   = NOP_INS;
    out_adel  = 1'b0;
    if (!empty) begin
      out_pc   = head.pc;
      out_adel = head.adel;
      // Garbage behind an address error must not look like a reserved
      // instruction to the decoder; the adel flag carries the real cause.
      if (!head.adel) out_ins = head.ins;
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue
//   Self-checking bench for inst_fetch_queue. A queue-based reference model
//   tracks which entries are held; directed scenarios are followed by a
//   randomized run with per-cycle comparisons of every output.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        adel;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ins;
  logic        in_adel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_adel;
  logic [2:0]  count;

  ent_t model[$];
  int   n_checks;
  int   n_fail;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_ins   (in_ins),
    .in_adel  (in_adel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_ins  (out_ins),
    .out_adel (out_adel),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs derived from the model contents.
  function automatic logic [31:0] exp_pc();
    return (model.size() == 0) ? 32'h0 : model[0].pc;
  endfunction
  function automatic logic [31:0] exp_ins();
    if (model.size() == 0) return 32'h0;
    return model[0].adel ? 32'h0 : model[0].ins;
  endfunction
  function automatic logic exp_adel();
    return (model.size() == 0) ? 1'b0 : model[0].adel;
  endfunction

  // Advance one clock and update the model from the inputs held before it.
  task automatic tick();
    bit   do_push, do_pop, do_clear;
    ent_t e;
    do_clear = rst || flush;
    do_push  = in_valid && (model.size() < DEPTH);
    do_pop   = out_ready && (model.size() > 0);
    e.pc = in_pc; e.ins = in_ins; e.adel = in_adel;
    @(posedge clk);
    #1;
    if (do_clear) model.delete();
    else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back(e);
    end
  endtask

  task automatic drive_entry(input logic [31:0] pc, input logic [31:0] ins, input logic adel);
    in_valid = 1'b1; in_pc = pc; in_ins = ins; in_adel = adel;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rst = 1'b0;
    in_pc = 32'h0; in_ins = 32'h0; in_adel = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    n_checks++; if (out_ins !== 32'h0) begin n_fail++; $display("FAIL reset_out_ins: got %h expected 0", out_ins); end
    n_checks++; if (out_adel !== 1'b0) begin n_fail++; $display("FAIL reset_out_adel: got %b expected 0", out_adel); end
    $display("test_reset done");
  endtask

  task automatic test_first_push();
    drive_entry(32'hBFC0_0000, 32'h2408_0001, 1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL first_out_pc: got %h expected bfc00000", out_pc); end
    n_checks++; if (out_ins !== 32'h2408_0001) begin n_fail++; $display("FAIL first_out_ins: got %h expected 24080001", out_ins); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL first_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_drain: got %b expected 0", out_valid); end
    $display("test_first_push done");
  endtask

  // Fill with the decoder stalled, then hold a fifth entry against full.
  task automatic test_fill_stall();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_entry(32'h0040_0000 + 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0);
      tick();
      n_checks++;
      if (out_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL stall_head_pc: cycle %0d got %h expected 00400000", i, out_pc); end
      if (i >= DEPTH - 1) i = (i == DEPTH + 1) ? i : i; // keep loop index untouched
    end
    // Loop held pc index DEPTH after the first DEPTH pushes; restore held 5th.
    drive_entry(32'h0040_0010, 32'h1000_0004, 1'b0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_ins !== 32'h1000_0000) begin n_fail++; $display("FAIL full_head_ins: got %h expected 10000000", out_ins); end
    $display("test_fill_stall done");
  endtask

  // Full with a pending push and a pop: pop only, then push lands; order
  // checked against the model across pointer wrap.
  task automatic test_full_pop_wrap();
    out_ready = 1'b1;
    tick();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 3", count); end
    out_ready = 1'b0;
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL held_push_count: got %0d expected 4", count); end
    for (int i = 0; i < 12; i++) begin
      if (i < 5) drive_entry(32'h0080_0000 + 32'(i * 4), $urandom, 1'b0);
      else in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_pc !== exp_pc()) begin n_fail++; $display("FAIL wrap_order_pc: step %0d got %h expected %h", i, out_pc, exp_pc()); end
      n_checks++;
      if (count !== 3'(model.size())) begin n_fail++; $display("FAIL wrap_count: step %0d got %0d expected %0d", i, count, model.size()); end
    end
    out_ready = 1'b0;
    $display("test_full_pop_wrap done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive_entry(32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
      tick();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL preflush_count: got %0d expected 3", count); end
    drive_entry(32'h0000_2000, 32'hDEAD_BEEF, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_ins !== 32'h0) begin n_fail++; $display("FAIL flush_out_ins: got %h expected 0", out_ins); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL flush_out_pc: got %h expected 0", out_pc); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got %b expected 0", out_valid); end
    $display("test_flush done");
  endtask

  task automatic test_adel();
    drive_entry(32'hBFC0_0002, 32'hFFFF_FFFF, 1'b1);
    tick();
    in_valid = 1'b0; in_adel = 1'b0;
    n_checks++; if (out_adel !== 1'b1) begin n_fail++; $display("FAIL adel_flag: got %b expected 1", out_adel); end
    n_checks++; if (out_ins !== 32'h0) begin n_fail++; $display("FAIL adel_ins: got %h expected 0", out_ins); end
    n_checks++; if (out_pc !== 32'hBFC0_0002) begin n_fail++; $display("FAIL adel_pc: got %h expected bfc00002", out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("test_adel done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive_entry(32'h0000_3000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0);
      tick();
    end
    drive_entry(32'h0000_3008, 32'hB000_0002, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive_entry(32'h0000_4000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_pc !== 32'h0000_4000 + 32'(i * 4)) begin n_fail++; $display("FAIL midrst_order: pop %0d got %h expected %h", i, out_pc, 32'h0000_4000 + 32'(i * 4)); end
      tick();
    end
    out_ready = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      flush     = ($urandom_range(0, 99) < 4);
      in_adel   = ($urandom_range(0, 99) < 15);
      in_ins    = $urandom;
      in_pc     = {$urandom_range(0, 32'h00FF_FFFF) << 2} | (in_adel ? 32'(2) : 32'(0));
      tick();
      n_checks++; if (count !== 3'(model.size())) begin n_fail++; $display("FAIL rand_count: cyc %0d got %0d expected %0d", i, count, model.size()); end
      n_checks++; if (out_valid !== (model.size() != 0)) begin n_fail++; $display("FAIL rand_out_valid: cyc %0d got %b expected %b", i, out_valid, model.size() != 0); end
      n_checks++; if (in_ready !== (model.size() != DEPTH)) begin n_fail++; $display("FAIL rand_in_ready: cyc %0d got %b expected %b", i, in_ready, model.size() != DEPTH); end
      n_checks++; if (out_pc !== exp_pc()) begin n_fail++; $display("FAIL rand_out_pc: cyc %0d got %h expected %h", i, out_pc, exp_pc()); end
      n_checks++; if (out_ins !== exp_ins()) begin n_fail++; $display("FAIL rand_out_ins: cyc %0d got %h expected %h", i, out_ins, exp_ins()); end
      n_checks++; if (out_adel !== exp_adel()) begin n_fail++; $display("FAIL rand_out_adel: cyc %0d got %b expected %b", i, out_adel, exp_adel()); end
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_first_push();
    test_fill_stall();
    test_full_pop_wrap();
    test_flush();
    test_adel();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
